// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the dual-port FIFO slice.
// Latency: not applicable (compile-time constants only).
// Backpressure: not applicable.
//
// Holds the default geometry and the pointer-width helper that both the
// storage and the control logic derive their address widths from.
package fifo_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_WIDTH = 8;

    // Address bits needed to index DEPTH entries; never narrower than one bit
    // so a degenerate depth still yields a legal vector.
    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_dualport_if.sv
// Handshake/data bundle between a FIFO producer/consumer and the FIFO.
// Latency: none (wires only).
// Backpressure: producer must observe full/overflow; consumer observes empty/underflow.
//
// Ports (via modports):
//   master : drives wr_en, rd_en, data_in; observes data_out, count and flags
//   slave  : the FIFO side, the mirror image of master
interface fifo_dualport_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = ptr_width(DEFAULT_DEPTH) + 1
);

    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, rd_en, data_in,
        input  data_out, full, empty, count,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  wr_en, rd_en, data_in,
        output data_out, full, empty, count,
               almost_full, almost_empty, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one synchronous read port.
// Latency: read data appears one clock after rd_en; writes land on the same edge.
// Backpressure: none; the caller guarantees only legal accesses are issued.
//
// Ports: clk, rst (clears only the read register), wr_en/wr_addr/wr_data,
//        rd_en/rd_addr, rd_data (registered, holds when rd_en is low).
module fifo_ram
    import fifo_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int AW    = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Array is left unreset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write: when a full FIFO reads and writes the same slot in
    // one cycle, the read returns the old (oldest) word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_dualport.sv
// Single-clock FIFO with occupancy count, almost flags and error pulses.
// Latency: data_out updates on the edge that accepts a read (1 cycle).
// Backpressure: writes on full (without a same-cycle read) and reads on empty are dropped and pulse overflow/underflow.
//
// Ports: clk, rst (synchronous, active-low), bus (fifo_dualport_if.slave):
//   wr_en/data_in write side, rd_en/data_out read side, count, full, empty,
//   almost_full (count >= AF_LEVEL), almost_empty (count <= AE_LEVEL),
//   overflow/underflow one-cycle pulses.
module fifo_dualport
    import fifo_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    fifo_dualport_if.slave    bus
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          underflow_q;

    logic          full_w;
    logic          empty_w;
    logic          rd_acc;
    logic          wr_acc;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // Reset masks both accepts so nothing reaches storage or pointers.
    // A full FIFO may still take a write when a read frees a slot that cycle.
    assign rd_acc = rst && bus.rd_en && !empty_w;
    assign wr_acc = rst && bus.wr_en && (!full_w || rd_acc);

    fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (bus.data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (bus.data_out)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            // DEPTH is a power of two, so natural pointer rollover is modulo DEPTH.
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            overflow_q  <= bus.wr_en && !wr_acc;
            underflow_q <= bus.rd_en && empty_w;
        end
    end

    assign bus.count        = count_q;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_dualport.sv
// Directed bench for fifo_dualport with a read-data scoreboard.
// Latency: expects data_out one edge after an accepted read.
// Backpressure: exercises overflow on full, underflow on empty, read+write on full.
module tb_fifo_dualport;
    import fifo_pkg::*;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int CW    = ptr_width(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_dualport_if #(.WIDTH(WIDTH), .CNT_W(CW)) bus ();

    fifo_dualport #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];
    logic [7:0] last_exp = 8'h00;
    bit         tb_rd_acc = 1'b0;
    int         mdl_cnt = 0;
    bit         exp_ovf = 1'b0;
    bit         exp_unf = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Monitor: on every edge, an accepted read must present the next queued
    // value; any other edge must leave data_out untouched; reset forces zero.
    always @(posedge clk) begin
        bit         fire;
        bit         in_rst;
        logic [7:0] e;
        fire   = tb_rd_acc;
        in_rst = !rst;
        #1;
        if (in_rst) begin
            chk("dout_reset", 32'(bus.data_out), 32'h0);
            last_exp = 8'h00;
        end else if (fire) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL scoreboard_underrun at %0t: got %0h expected none", $time, bus.data_out);
            end else begin
                e = exp_q.pop_front();
                chk("dout", 32'(bus.data_out), 32'(e));
                last_exp = e;
            end
        end else begin
            chk("dout_hold", 32'(bus.data_out), 32'(last_exp));
        end
    end

    task automatic chk_flags();
        chk("count",        32'(bus.count),        32'(mdl_cnt));
        chk("empty",        32'(bus.empty),        32'(mdl_cnt == 0));
        chk("full",         32'(bus.full),         32'(mdl_cnt == DEPTH));
        chk("almost_full",  32'(bus.almost_full),  32'(mdl_cnt >= DEPTH - 2));
        chk("almost_empty", 32'(bus.almost_empty), 32'(mdl_cnt <= 2));
        chk("overflow",     32'(bus.overflow),     32'(exp_ovf));
        chk("underflow",    32'(bus.underflow),    32'(exp_unf));
    endtask

    // One clock of stimulus, entered and left at a falling edge. e is the
    // hand-computed word that an accepted read must return.
    task automatic step(input bit w, input bit r, input logic [7:0] d, input logic [7:0] e);
        bit ra;
        bit wa;
        ra = r && (mdl_cnt > 0);
        wa = w && ((mdl_cnt < DEPTH) || ra);
        bus.wr_en   = w;
        bus.rd_en   = r;
        bus.data_in = d;
        tb_rd_acc   = ra;
        if (ra) exp_q.push_back(e);
        exp_ovf = w && !wa;
        exp_unf = r && (mdl_cnt == 0);
        @(posedge clk);
        mdl_cnt = mdl_cnt + int'(wa) - int'(ra);
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        tb_rd_acc = 1'b0;
        chk_flags();
    endtask

    task automatic wr(input logic [7:0] d);
        step(1'b1, 1'b0, d, 8'h00);
    endtask

    task automatic rd(input logic [7:0] e);
        step(1'b0, 1'b1, 8'h00, e);
    endtask

    // Requests held high through reset must be ignored.
    task automatic do_reset();
        rst         = 1'b0;
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        bus.data_in = 8'hEE;
        tb_rd_acc   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        mdl_cnt   = 0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
        exp_q.delete();
        chk_flags();
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] e;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = 8'h00;

        do_reset();

        // Basic ordering.
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44); wr(8'h55);
        rd(8'h11); rd(8'h22); rd(8'h33);
        chk("count_after_3rd", 32'(bus.count), 32'd2);

        // Drain to empty, then read on empty holds AA and pulses underflow.
        wr(8'h66); wr(8'h77); wr(8'h88); wr(8'h99); wr(8'hAA);
        rd(8'h44); rd(8'h55); rd(8'h66); rd(8'h77); rd(8'h88); rd(8'h99); rd(8'hAA);
        rd(8'h00);
        chk("underflow_pulse", 32'(bus.underflow), 32'd1);
        wr(8'h01);
        rd(8'h01);

        // Fill to full; extra write dropped with overflow.
        for (int i = 0; i < 16; i++) wr(8'(i));
        chk("count_full", 32'(bus.count), 32'd16);
        wr(8'hFF);
        chk("overflow_pulse", 32'(bus.overflow), 32'd1);
        chk("full_after_ovf", 32'(bus.full), 32'd1);

        // Drain exactly 00..0F, then a read on empty keeps 0F.
        for (int i = 0; i < 16; i++) rd(8'(i));
        rd(8'h00);

        // Read+write on full: oldest out, full stays, 5A comes out last.
        for (int i = 0; i < 16; i++) wr(8'(8'h20 + i));
        step(1'b1, 1'b1, 8'h5A, 8'h20);
        chk("full_after_rw", 32'(bus.full), 32'd1);
        for (int i = 1; i < 16; i++) rd(8'(8'h20 + i));
        rd(8'h5A);

        // Sustained read+write on full across several pointer laps.
        for (int i = 0; i < 16; i++) wr(8'(8'h20 + i));
        for (int k = 0; k < 40; k++) begin
            d = (k == 0) ? 8'h5A : 8'(8'h80 + k);
            if (k < 16)       e = 8'(8'h20 + k);
            else if (k == 16) e = 8'h5A;
            else              e = 8'(8'h80 + k - 16);
            step(1'b1, 1'b1, d, e);
        end
        for (int j = 0; j < 16; j++) rd(8'(8'h98 + j));

        // Mid-stream reset discards stored words.
        wr(8'hA1); wr(8'hA2); wr(8'hA3); wr(8'hA4); wr(8'hA5);
        do_reset();
        chk("dout_after_rst", 32'(bus.data_out), 32'h0);
        wr(8'hC3);
        rd(8'hC3);
        rd(8'h00);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
